fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction memory (TLB + instruction cache). It owns the program counter, drives the virtual fetch address and enable into the instruction memory, and holds fetch while a line fill is outstanding. It selects the 32-bit instruction word out of the returned cache line and registers it, together with its PC, for the decode stage. It converts TLB misses and misaligned redirects into a held fault toward the exception logic.

---
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage in front of the instruction memory (TLB + I-cache).
//   Owns the PC, issues one lookup per cycle, waits out cache line fills,
//   selects the 32-bit word from the returned line and registers it with its
//   PC for decode. TLB misses and misaligned redirect targets become a held
//   fault that only a redirect clears.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   i_stall           decode cannot accept; holds the output register
//   i_redirect(_pc)   redirect from a later stage (highest priority)
//   o_ime_enable/va   lookup request / virtual address (va is always pc)
//   i_ime_data        cache line for o_ime_va
//   i_ime_tlb_miss    TLB miss for o_ime_va
//   i_ime_cache_miss  cache miss for o_ime_va
//   o_valid/instr/pc  registered instruction toward decode
//   o_exception/exc_cause/exc_addr  held fetch fault (01 TLB, 10 misaligned)
module fetch_unit #(
  parameter int unsigned         VA_WIDTH    = 32,
  parameter int unsigned         CACHE_BYTES = 16,
  parameter logic [VA_WIDTH-1:0] RESET_PC    = 'h0000_1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_stall,
  input  logic                     i_redirect,
  input  logic [VA_WIDTH-1:0]      i_redirect_pc,
  output logic                     o_ime_enable,
  output logic [VA_WIDTH-1:0]      o_ime_va,
  input  logic [CACHE_BYTES*8-1:0] i_ime_data,
  input  logic                     i_ime_tlb_miss,
  input  logic                     i_ime_cache_miss,
  output logic                     o_valid,
  output logic [31:0]              o_instr,
  output logic [VA_WIDTH-1:0]      o_pc,
  output logic                     o_exception,
  output logic [1:0]               o_exc_cause,
  output logic [VA_WIDTH-1:0]      o_exc_addr
);

  localparam int unsigned WORDS = CACHE_BYTES / 4;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_TLB      = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

  typedef enum logic [1:0] {
    RUN,
    MISS_WAIT,
    FAULT
  } state_t;

  state_t              state, state_next;
  logic [VA_WIDTH-1:0] pc, pc_next;
  logic                valid_next;
  logic [31:0]         instr_next;
  logic [VA_WIDTH-1:0] pc_out_next;
  logic                exc_next;
  logic [1:0]          cause_next;
  logic [VA_WIDTH-1:0] exc_addr_next;

  logic                hold;
  logic [VA_WIDTH-1:0] word_idx;
  logic [31:0]         line_word;

  assign hold         = o_valid && i_stall;
  assign o_ime_enable = !rst && (state != FAULT) && !hold && !i_redirect;
  assign o_ime_va     = pc;

  // Word index within the line: byte offset bits above the 2-bit word offset.
  // Masking keeps this valid even when the line holds a single word.
  assign word_idx = (pc & VA_WIDTH'(CACHE_BYTES - 1)) >> 2;

  always_comb begin
    line_word = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (word_idx == VA_WIDTH'(w)) line_word = i_ime_data[w*32 +: 32];
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    valid_next    = o_valid;
    instr_next    = o_instr;
    pc_out_next   = o_pc;
    exc_next      = o_exception;
    cause_next    = o_exc_cause;
    exc_addr_next = o_exc_addr;

    if (i_redirect) begin
      // Flush and retarget; any lookup result this cycle is ignored.
      valid_next = 1'b0;
      exc_next   = 1'b0;
      cause_next = CAUSE_NONE;
      pc_next    = i_redirect_pc;
      state_next = RUN;
      if (i_redirect_pc[1:0] != 2'b00) begin
        state_next    = FAULT;
        exc_next      = 1'b1;
        cause_next    = CAUSE_MISALIGN;
        exc_addr_next = i_redirect_pc;
      end
    end else if (o_ime_enable) begin
      if (i_ime_tlb_miss) begin
        state_next    = FAULT;
        valid_next    = 1'b0;
        exc_next      = 1'b1;
        cause_next    = CAUSE_TLB;
        exc_addr_next = pc;
      end else if (i_ime_cache_miss) begin
        state_next = MISS_WAIT;
        valid_next = 1'b0;
      end else begin
        state_next  = RUN;
        valid_next  = 1'b1;
        instr_next  = line_word;
        pc_out_next = pc;
        pc_next     = pc + VA_WIDTH'(4);
      end
    end else if (!hold) begin
      // Output consumed (or nothing valid) and no new instruction arrived.
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      o_valid     <= 1'b0;
      o_instr     <= '0;
      o_pc        <= '0;
      o_exception <= 1'b0;
      o_exc_cause <= CAUSE_NONE;
      o_exc_addr  <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      o_valid     <= valid_next;
      o_instr     <= instr_next;
      o_pc        <= pc_out_next;
      o_exception <= exc_next;
      o_exc_cause <= cause_next;
      o_exc_addr  <= exc_addr_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed stimulus pushes expected
// instructions/faults into queues; a negedge monitor pops and compares them.
module tb_fetch_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_stall;
  logic         i_redirect;
  logic [31:0]  i_redirect_pc;
  logic         o_ime_enable;
  logic [31:0]  o_ime_va;
  logic [127:0] i_ime_data;
  logic         i_ime_tlb_miss;
  logic         i_ime_cache_miss;
  logic         o_valid;
  logic [31:0]  o_instr;
  logic [31:0]  o_pc;
  logic         o_exception;
  logic [1:0]   o_exc_cause;
  logic [31:0]  o_exc_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];
  logic [1:0]  exp_cause_q[$];
  logic [31:0] exp_addr_q[$];

  always #5 clk = ~clk;

  // Every line holds word k = 'hA000_000k.
  assign i_ime_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

  fetch_unit #(
    .VA_WIDTH   (32),
    .CACHE_BYTES(16),
    .RESET_PC   (32'h0000_1000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_stall         (i_stall),
    .i_redirect      (i_redirect),
    .i_redirect_pc   (i_redirect_pc),
    .o_ime_enable    (o_ime_enable),
    .o_ime_va        (o_ime_va),
    .i_ime_data      (i_ime_data),
    .i_ime_tlb_miss  (i_ime_tlb_miss),
    .i_ime_cache_miss(i_ime_cache_miss),
    .o_valid         (o_valid),
    .o_instr         (o_instr),
    .o_pc            (o_pc),
    .o_exception     (o_exception),
    .o_exc_cause     (o_exc_cause),
    .o_exc_addr      (o_exc_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hit(input logic [31:0] pc);
    logic [31:0] instr;
    instr = 32'hA000_0000 | {30'd0, pc[3:2]};
    exp_pc_q.push_back(pc);
    exp_instr_q.push_back(instr);
  endtask

  task automatic push_exc(input logic [1:0] cause, input logic [31:0] addr);
    exp_cause_q.push_back(cause);
    exp_addr_q.push_back(addr);
  endtask

  // Monitor: an instruction is delivered on each cycle with o_valid && !i_stall;
  // a fault is delivered on each rising edge of o_exception.
  initial begin
    logic        exc_prev;
    logic [31:0] e_pc, e_instr, e_addr;
    logic [1:0]  e_cause;
    exc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_valid && !i_stall) begin
          if (exp_pc_q.size() == 0) begin
            chk("unexpected_output_pc", o_pc, 32'hxxxx_xxxx);
          end else begin
            e_pc    = exp_pc_q.pop_front();
            e_instr = exp_instr_q.pop_front();
            chk("out_pc", o_pc, e_pc);
            chk("out_instr", o_instr, e_instr);
          end
        end
        if (o_exception && !exc_prev) begin
          if (exp_cause_q.size() == 0) begin
            chk("unexpected_exception", {30'd0, o_exc_cause}, 32'hxxxx_xxxx);
          end else begin
            e_cause = exp_cause_q.pop_front();
            e_addr  = exp_addr_q.pop_front();
            chk("exc_cause", {30'd0, o_exc_cause}, {30'd0, e_cause});
            chk("exc_addr", o_exc_addr, e_addr);
          end
        end
        exc_prev = o_exception;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    i_ime_tlb_miss = 1'b0; i_ime_cache_miss = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_exc", {31'd0, o_exception}, 32'd0);
    chk("rst_cause", {30'd0, o_exc_cause}, 32'd0);
    chk("rst_enable", {31'd0, o_ime_enable}, 32'd0);
    chk("rst_va", o_ime_va, 32'h1000);
    cyc();
    rst = 1'b0;

    // Sequential hits from the reset PC.
    for (int unsigned k = 0; k < 4; k++) begin
      push_hit(32'h1000 + 4 * k);
      @(negedge clk);
      chk("seq_va", o_ime_va, 32'h1000 + 4 * k);
      chk("seq_enable", {31'd0, o_ime_enable}, 32'd1);
      cyc();
    end

    // Cache miss for 3 cycles at 'h1010, then hit.
    i_ime_cache_miss = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("miss_va", o_ime_va, 32'h1010);
      chk("miss_enable", {31'd0, o_ime_enable}, 32'd1);
      if (k > 0) chk("miss_valid", {31'd0, o_valid}, 32'd0);
      cyc();
    end
    i_ime_cache_miss = 1'b0;
    push_hit(32'h1010);
    @(negedge clk);
    chk("miss_hit_va", o_ime_va, 32'h1010);
    chk("miss_hit_valid", {31'd0, o_valid}, 32'd0);
    cyc();

    // TLB miss with simultaneous cache miss at 'h1020.
    for (int unsigned k = 1; k < 4; k++) begin
      push_hit(32'h1010 + 4 * k);
      cyc();
    end
    i_ime_tlb_miss = 1'b1; i_ime_cache_miss = 1'b1;
    push_exc(2'b01, 32'h1020);
    @(negedge clk);
    chk("tlb_va", o_ime_va, 32'h1020);
    cyc();
    i_ime_tlb_miss = 1'b0; i_ime_cache_miss = 1'b0;
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("tlb_hold_exc", {31'd0, o_exception}, 32'd1);
      chk("tlb_hold_cause", {30'd0, o_exc_cause}, 32'd1);
      chk("tlb_hold_addr", o_exc_addr, 32'h1020);
      chk("tlb_hold_enable", {31'd0, o_ime_enable}, 32'd0);
      chk("tlb_hold_valid", {31'd0, o_valid}, 32'd0);
      cyc();
    end
    i_redirect = 1'b1; i_redirect_pc = 32'h2000;
    @(negedge clk);
    chk("redir_enable", {31'd0, o_ime_enable}, 32'd0);
    cyc();
    i_redirect = 1'b0;
    push_hit(32'h2000);
    @(negedge clk);
    chk("redir_exc_clear", {31'd0, o_exception}, 32'd0);
    chk("redir_va", o_ime_va, 32'h2000);
    chk("redir_en", {31'd0, o_ime_enable}, 32'd1);
    cyc();
    push_hit(32'h2004);
    cyc();

    // Stall while o_pc = 'h1004.
    i_redirect = 1'b1; i_redirect_pc = 32'h1000;
    cyc();
    i_redirect = 1'b0;
    push_hit(32'h1000);
    cyc();
    push_hit(32'h1004);
    cyc();
    i_stall = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, o_valid}, 32'd1);
      chk("stall_pc", o_pc, 32'h1004);
      chk("stall_instr", o_instr, 32'hA000_0001);
      chk("stall_enable", {31'd0, o_ime_enable}, 32'd0);
      chk("stall_va", o_ime_va, 32'h1008);
      cyc();
    end
    i_stall = 1'b0;
    push_hit(32'h1008);
    @(negedge clk);
    chk("unstall_va", o_ime_va, 32'h1008);
    cyc();
    cyc();  // lookup of 'h100C, flushed below

    // Redirect during stall.
    i_stall = 1'b1;
    @(negedge clk);
    chk("stall2_pc", o_pc, 32'h100C);
    cyc();
    i_redirect = 1'b1; i_redirect_pc = 32'h3000;
    @(negedge clk);
    chk("stall_redir_enable", {31'd0, o_ime_enable}, 32'd0);
    cyc();
    i_redirect = 1'b0; i_stall = 1'b0;
    push_hit(32'h3000);
    @(negedge clk);
    chk("stall_redir_flush", {31'd0, o_valid}, 32'd0);
    chk("stall_redir_va", o_ime_va, 32'h3000);
    cyc();

    // Redirect during cache miss at 'h3004.
    i_ime_cache_miss = 1'b1;
    cyc();
    i_redirect = 1'b1; i_redirect_pc = 32'h3000;
    @(negedge clk);
    chk("miss_redir_valid0", {31'd0, o_valid}, 32'd0);
    cyc();
    i_redirect = 1'b0; i_ime_cache_miss = 1'b0;
    push_hit(32'h3000);
    @(negedge clk);
    chk("miss_redir_valid1", {31'd0, o_valid}, 32'd0);
    chk("miss_redir_va", o_ime_va, 32'h3000);
    cyc();

    // Misaligned redirect to 'h3002.
    i_redirect = 1'b1; i_redirect_pc = 32'h3002;
    push_exc(2'b10, 32'h3002);
    cyc();
    i_redirect = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mis_exc", {31'd0, o_exception}, 32'd1);
      chk("mis_cause", {30'd0, o_exc_cause}, 32'd2);
      chk("mis_addr", o_exc_addr, 32'h3002);
      chk("mis_enable", {31'd0, o_ime_enable}, 32'd0);
      chk("mis_valid", {31'd0, o_valid}, 32'd0);
      cyc();
    end

    // PC wrap.
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    cyc();
    i_redirect = 1'b0;
    push_hit(32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_va0", o_ime_va, 32'hFFFF_FFFC);
    chk("wrap_exc_clear", {31'd0, o_exception}, 32'd0);
    cyc();
    push_hit(32'h0000_0000);
    @(negedge clk);
    chk("wrap_va1", o_ime_va, 32'h0000_0000);
    cyc();
    i_redirect = 1'b1; i_redirect_pc = 32'h1000;
    cyc();
    cyc();
    @(negedge clk);
    chk("drain_instr", exp_pc_q.size(), 32'd0);
    chk("drain_exc", exp_cause_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
